// File: rtl/modport_fifo.sv
// Single-clock byte FIFO with occupancy counter, full/empty flags and
// one-cycle overflow/underflow pulses for rejected accesses.
module modport_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                  wr_clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  full,
   output logic                  empty,
   output logic [CNT_WIDTH-1:0]  fifo_counter,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int                   PTR_WIDTH = $clog2(DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = CNT_WIDTH'(0);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
   localparam logic [PTR_WIDTH-1:0] PTR_ZERO  = PTR_WIDTH'(0);
   localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_WIDTH-1:0]  wptr_r;
   logic [PTR_WIDTH-1:0]  rptr_r;
   logic [CNT_WIDTH-1:0]  cnt_r;
   logic                  wr_accept_s;
   logic                  rd_accept_s;

   // Flag decode and access acceptance, all from the pre-edge counter.
   always_comb begin
      full        = (cnt_r == CNT_FULL);
      empty       = (cnt_r == CNT_ZERO);
      wr_accept_s = wr_en && !full;
      rd_accept_s = rd_en && !empty;
   end

   assign fifo_counter = cnt_r;

   // Storage array; not cleared by reset, but reset blocks a same-cycle write.
   always_ff @(posedge wr_clk) begin
      if (!rst && wr_accept_s) begin
         mem_r[wptr_r] <= wdata;
      end
   end

   // Pointers wrap naturally since they are exactly log2(DEPTH) bits wide.
   always_ff @(posedge wr_clk) begin
      if (rst) begin
         wptr_r <= PTR_ZERO;
         rptr_r <= PTR_ZERO;
      end else begin
         if (wr_accept_s) begin
            wptr_r <= wptr_r + PTR_ONE;
         end
         if (rd_accept_s) begin
            rptr_r <= rptr_r + PTR_ONE;
         end
      end
   end

   // Occupancy counter: moves only when exactly one side is accepted.
   always_ff @(posedge wr_clk) begin
      if (rst) begin
         cnt_r <= CNT_ZERO;
      end else begin
         case ({wr_accept_s, rd_accept_s})
            2'b10:   cnt_r <= cnt_r + CNT_ONE;
            2'b01:   cnt_r <= cnt_r - CNT_ONE;
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // Registered read data (held when no read is accepted) and error pulses.
   always_ff @(posedge wr_clk) begin
      if (rst) begin
         rdata     <= {DATA_WIDTH{1'b0}};
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (rd_accept_s) begin
            rdata <= mem_r[rptr_r];
         end
         overflow  <= wr_en && full;
         underflow <= rd_en && empty;
      end
   end

endmodule

// File: tb/tb_modport_fifo.sv
// Scoreboard bench for modport_fifo: a queue-based reference model predicts
// the post-edge state of every stimulus cycle; a monitor compares it.
module tb_modport_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int CW    = 4;

   logic          wr_clk = 1'b0;
   logic          rst    = 1'b0;
   logic          wr_en  = 1'b0;
   logic [DW-1:0] wdata  = 8'h00;
   logic          rd_en  = 1'b0;
   logic [DW-1:0] rdata;
   logic          full;
   logic          empty;
   logic [CW-1:0] fifo_counter;
   logic          overflow;
   logic          underflow;

   modport_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
      .wr_clk       (wr_clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wdata        (wdata),
      .rd_en        (rd_en),
      .rdata        (rdata),
      .full         (full),
      .empty        (empty),
      .fifo_counter (fifo_counter),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   always #5 wr_clk = ~wr_clk;

   typedef struct {
      int        cnt;
      bit        full;
      bit        empty;
      bit        ovf;
      bit        unf;
      bit [7:0]  data;
      string     tag;
   } exp_t;

   exp_t     exp_q[$];
   bit [7:0] model_q[$];
   bit [7:0] last_rdata = 8'h00;
   int       n_tests = 0;
   int       n_fail  = 0;

   task automatic check(input string name, input string tag, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s [%s]: got 0x%0h, expected 0x%0h at %0t", name, tag, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus on the falling edge and predict its outcome.
   task automatic step(input bit r, input bit w, input bit [7:0] d, input bit rd, input string tag);
      exp_t e;
      bit   was_full;
      bit   was_empty;
      @(negedge wr_clk);
      rst = r; wr_en = w; wdata = d; rd_en = rd;
      e.ovf = 1'b0;
      e.unf = 1'b0;
      if (r) begin
         model_q.delete();
         last_rdata = 8'h00;
      end else begin
         was_full  = (model_q.size() == DEPTH);
         was_empty = (model_q.size() == 0);
         e.ovf = w && was_full;
         e.unf = rd && was_empty;
         if (rd && !was_empty) last_rdata = model_q.pop_front();
         if (w && !was_full) model_q.push_back(d);
      end
      e.cnt   = model_q.size();
      e.full  = (model_q.size() == DEPTH);
      e.empty = (model_q.size() == 0);
      e.data  = last_rdata;
      e.tag   = tag;
      exp_q.push_back(e);
   endtask

   // Monitor: after each rising edge, compare the DUT against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge wr_clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("fifo_counter", e.tag, int'(fifo_counter), e.cnt);
            check("full",         e.tag, int'(full),         int'(e.full));
            check("empty",        e.tag, int'(empty),        int'(e.empty));
            check("overflow",     e.tag, int'(overflow),     int'(e.ovf));
            check("underflow",    e.tag, int'(underflow),    int'(e.unf));
            check("rdata",        e.tag, int'(rdata),        int'(e.data));
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int waited;
      // Reset held two cycles with both requests asserted
      step(1'b1, 1'b1, 8'h77, 1'b1, "reset0");
      step(1'b1, 1'b1, 8'h77, 1'b1, "reset1");
      step(1'b0, 1'b0, 8'h00, 1'b0, "idle");
      // Fill with 0x01..0x08, then overflow with 0xAA
      for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 8'(i), 1'b0, "fill");
      step(1'b0, 1'b1, 8'hAA, 1'b0, "overflow");
      step(1'b0, 1'b0, 8'h00, 1'b0, "ovf_clear");
      // Drain, then underflow with rdata held
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 8'h00, 1'b1, "drain");
      step(1'b0, 1'b0, 8'h00, 1'b1, "underflow");
      step(1'b0, 1'b0, 8'h00, 1'b0, "unf_clear");
      // Empty with simultaneous read+write: write only, no bypass
      step(1'b0, 1'b1, 8'h3C, 1'b1, "empty_rw");
      step(1'b0, 1'b0, 8'h00, 1'b1, "empty_rw_rd");
      // Wrap: 5 writes, 3 reads, 6 writes
      for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, "wrap_w5");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, "wrap_r3");
      for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(8'h20 + i), 1'b0, "wrap_w6");
      // Full with simultaneous read+write: read only
      step(1'b0, 1'b1, 8'hEE, 1'b1, "full_rw");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, "to_four");
      // At count 4, concurrent read+write keeps the count
      step(1'b0, 1'b1, 8'h44, 1'b1, "cnt4_rw");
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 1'b1, "wrap_drain");
      // Mid-operation reset with 3 words stored
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'(8'h90 + i), 1'b0, "pre_rst");
      step(1'b1, 1'b0, 8'h00, 1'b0, "mid_rst");
      step(1'b0, 1'b1, 8'h5C, 1'b0, "post_rst_w");
      step(1'b0, 1'b0, 8'h00, 1'b1, "post_rst_r");
      step(1'b0, 1'b0, 8'h00, 1'b0, "post_rst_idle");
      // Randomized traffic with shifting write/read bias
      for (int i = 0; i < 600; i++) begin
         int  wp;
         bit  r;
         bit  w;
         bit  rd;
         wp = ((i / 100) % 2 == 0) ? 70 : 30;
         r  = ($urandom_range(0, 99) < 2);
         w  = ($urandom_range(0, 99) < wp);
         rd = ($urandom_range(0, 99) < (100 - wp));
         step(r, w, 8'($urandom_range(0, 255)), rd, "random");
      end
      step(1'b0, 1'b0, 8'h00, 1'b0, "final_idle");
      waited = 0;
      while (exp_q.size() > 0 && waited < 20) begin
         @(posedge wr_clk);
         waited++;
      end
      #2;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_scoreboard: %0d predictions left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/modport_fifo.md
Name: modport_fifo

Overview:
- Single-clock synchronous byte FIFO behind the `intf` bus: `wdata`, `rdata`, `full`, `empty` and `fifo_counter`.
- Buffers 8-bit words between a producer and a consumer that share one clock.
- Exposes occupancy and full/empty status, plus one-cycle error pulses for rejected accesses.
- Sits between the bus-side driver and the downstream data consumer.

Parameters:
- DATA_WIDTH, 8, width of `wdata`/`rdata`.
- DEPTH, 8, number of storage entries; must be a power of two.
- CNT_WIDTH, 4, width of `fifo_counter`; must hold the values 0..DEPTH inclusive.

Ports:
- wr_clk  input  1  sole clock; both write and read ports are sampled on its rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- wdata  input  DATA_WIDTH  write data.
- rd_en  input  1  read request.
- rdata  output  DATA_WIDTH  registered read data.
- full  output  1  high when occupancy equals DEPTH.
- empty  output  1  high when occupancy equals 0.
- fifo_counter  output  CNT_WIDTH  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse when a write is rejected because the FIFO is full.
- underflow  output  1  one-cycle pulse when a read is rejected because the FIFO is empty.

Behaviour:
- Interface: one clock (`wr_clk`); reset `rst` is synchronous and active-high.
- Reset (`rst` = 1 at a rising edge):
  - write pointer, read pointer and `fifo_counter` go to 0;
  - `rdata` goes to 0;
  - `overflow` and `underflow` go to 0;
  - `empty` = 1, `full` = 0;
  - reset overrides any `wr_en`/`rd_en` in the same cycle;
  - storage contents need not be cleared; any data held before a mid-operation reset is discarded.
- Storage: DEPTH x DATA_WIDTH register array; pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
- Flags: `full` = (`fifo_counter` == DEPTH) and `empty` = (`fifo_counter` == 0), decoded combinationally from the registered counter.
- Write accept = `wr_en` && !`full`, evaluated on the pre-edge `full`:
  - `mem[wptr]` <= `wdata`;
  - `wptr` increments by 1, wrapping from DEPTH-1 to 0.
- Read accept = `rd_en` && !`empty`, evaluated on the pre-edge `empty`:
  - `rdata` <= `mem[rptr]`, so the data appears one cycle after the request edge;
  - `rptr` increments by 1 with wrap.
- `rdata` holds its last value when no read is accepted.
- Counter update:
  - +1 on write only;
  - -1 on read only;
  - unchanged when both or neither are accepted;
  - never leaves the range 0..DEPTH.
- Simultaneous `wr_en` and `rd_en`:
  - when neither flag is set, both are accepted and the count is unchanged;
  - when empty, only the write is accepted and `underflow` pulses; a same-cycle write is never bypassed to `rdata`;
  - when full, only the read is accepted and `overflow` pulses.
- `overflow` <= `wr_en` && `full`; `underflow` <= `rd_en` && `empty`. Both are registered, one-cycle, and have no side effects on pointers or data.
- Ordering: strict FIFO; data read back equals data written, in write order, including across pointer wrap.

Test Plan:
- Reset: hold `rst` = 1 for 2 cycles with `wr_en` = `rd_en` = 1 -> `empty` = 1, `full` = 0, `fifo_counter` = 0, `rdata` = 0x00, no error pulses.
- Fill: write 0x01..0x08 on consecutive cycles -> `fifo_counter` steps 1..8, `full` = 1 after the 8th write, `empty` = 0 after the 1st write.
- Overflow: with the FIFO full, write 0xAA -> `overflow` pulses for one cycle, `fifo_counter` stays 8; a later drain yields 0x01..0x08 with no 0xAA.
- Drain and underflow: read 8 times -> `rdata` = 0x01..0x08, each one cycle after its request, `empty` = 1; a 9th read -> `underflow` pulses for one cycle and `rdata` holds 0x08.
- Wrap and concurrency:
  - write 5 words, read 3, write 6 more -> `fifo_counter` = 8, `full` = 1, reads return words in order across the pointer wrap;
  - at count 4, simultaneous read+write -> count stays 4.
- Mid-operation reset: with 3 words stored, assert `rst` -> `fifo_counter` = 0, `empty` = 1; the next write 0x5C then read returns 0x5C.
